i2c_reg_access_ctrl: RTL and testbench
======================================

// Module: i2c_reg_access_ctrl
// PURPOSE
//   Transaction sequencer between the byte-level I2C slave engine and the PWM register file.
//   Matches the first byte after START against the latched 7-bit slave address.
//   Then runs a write (pointer byte + data bytes) or read (data bytes from the pointer) sequence.
//   Drives ACK/NACK decisions, register write strobes, read data and auto-incrementing pointer.
// PARAMETERS
//   NUM_REGS  70  number of addressable registers (valid pointers 0..NUM_REGS-1)
//   PTR_W     7   register pointer width, must satisfy 2**PTR_W >= NUM_REGS
//   AUTO_INC  1   1: pointer increments after each data byte; 0: pointer holds
// PORTS
//   clk_i            in   1      system clock, single clock domain
//   rst_i            in   1      asynchronous, active-high reset
//   slave_address_i  in   7      latched slave address
//   addr_ready_i     in   1      slave address valid; 0 = not yet latched
//   start_det_i      in   1      1-cycle pulse: START or repeated START seen
//   stop_det_i       in   1      1-cycle pulse: STOP seen
//   rx_valid_i       in   1      1-cycle pulse: rx_byte_i holds a received byte
//   rx_byte_i        in   8      received byte, MSB first as transmitted
//   tx_load_i        in   1      1-cycle pulse: engine needs next read byte
//   master_nack_i    in   1      1-cycle pulse: master NACKed the last transmitted byte
//   reg_rdata_i      in   8      combinational register-file read data at reg_addr_o
//   ack_valid_o      out  1      1-cycle pulse: ack_o is the decision for the last rx byte
//   ack_o            out  1      1 = ACK, 0 = NACK (meaningful with ack_valid_o)
//   tx_byte_o        out  8      byte to shift out on read
//   reg_addr_o       out  PTR_W  current register pointer
//   reg_wr_en_o      out  1      1-cycle write strobe
//   reg_wdata_o      out  8      write data, valid with reg_wr_en_o
//   busy_o           out  1      1 while state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE; pointer, tx_byte_o, reg_wdata_o = 0; all strobes and busy_o = 0.
//     Reset mid-transaction aborts it with no write strobe.
//   States: IDLE, ADDR, PTR, WR_DATA, RD_DATA, IGNORE.
//   Global rules, any state:
//     - start_det_i -> ADDR.
//     - else stop_det_i -> IDLE.
//     - START beats STOP, rx_valid_i and tx_load_i in the same cycle; the losers are dropped.
//   ADDR, on rx_valid_i:
//     - match = addr_ready_i && rx_byte_i[7:1]==slave_address_i.
//     - No match -> NACK, IGNORE.
//     - Match with rx_byte_i[0]=0 -> ACK, PTR.
//     - Match with rx_byte_i[0]=1 -> ACK, RD_DATA.
//   PTR, on rx_valid_i:
//     - rx_byte_i < NUM_REGS -> ACK, pointer=rx_byte_i[PTR_W-1:0], WR_DATA.
//     - Otherwise NACK, IGNORE; pointer unchanged.
//   WR_DATA, on rx_valid_i:
//     - ACK.
//     - Next cycle: reg_wr_en_o=1, reg_addr_o=old pointer, reg_wdata_o=rx_byte_i.
//     - Then pointer advances when AUTO_INC=1.
//   RD_DATA:
//     - On tx_load_i: tx_byte_o <= reg_rdata_i, registered with 1-cycle latency.
//     - The pointer advances in the same edge when AUTO_INC=1.
//     - master_nack_i -> IGNORE.
//     - rx_valid_i is ignored.
//   IGNORE: no ACKs (ack_valid_o with ack_o=0 on every rx_valid_i), no strobes; exits only via START/STOP.
//   IDLE: rx_valid_i ignored, no ack_valid_o.
//   ACK latency: ack_valid_o/ack_o asserted exactly 1 cycle after rx_valid_i; ack_o=0 when not valid.
//   Pointer wrap: NUM_REGS-1 -> 0. Pointer persists across transactions (a read without a PTR phase continues from the last pointer).
//   reg_wr_en_o never asserts outside WR_DATA; at most one strobe per rx byte.
// TESTING
//   1. Reset, addr_ready_i=1, slave_address_i=7'h52. START, rx 0xA4, rx 0x06, rx 0x11, rx 0x22, STOP.
//      -> 4 ACKs. Writes reg6=0x11, reg7=0x22. Pointer=8, busy_o=0 after STOP.
//   2. Address mismatch: START, rx 0xA6 (slave 7'h52), rx 0x55.
//      -> NACK on both, no reg_wr_en_o, state IGNORE until STOP.
//   3. Read with repeated START: write ptr 0x45 (69), then START, rx 0xA5, tx_load_i x2 (reg69=0xAB, reg0=0xCD), master_nack_i.
//      -> tx_byte_o 0xAB then 0xCD; pointer wraps 69->0->1.
//   4. Invalid pointer: START, rx 0xA4, rx 0x46 (70).
//      -> ACK then NACK. Pointer unchanged, later data bytes NACKed, no writes.
//   5. addr_ready_i=0: START, rx 0xA0 with pins yet unlatched -> NACK; no state beyond IGNORE.
//   6. Collisions and reset: START and rx_valid_i same cycle -> byte dropped, state ADDR.
//      Assert rst_i one cycle after a WR_DATA rx byte -> no reg_wr_en_o, all outputs 0.

Source files
------------

// File: rtl/i2c_reg_access_ctrl_if.sv
// Bus between the byte-level I2C slave engine / register file and the
// transaction sequencer. The slave modport is the sequencer's view.
interface i2c_reg_access_ctrl_if #(
  parameter int PTR_W = 7
);
  logic [6:0]       slave_address_i;
  logic             addr_ready_i;
  logic             start_det_i;
  logic             stop_det_i;
  logic             rx_valid_i;
  logic [7:0]       rx_byte_i;
  logic             tx_load_i;
  logic             master_nack_i;
  logic [7:0]       reg_rdata_i;
  logic             ack_valid_o;
  logic             ack_o;
  logic [7:0]       tx_byte_o;
  logic [PTR_W-1:0] reg_addr_o;
  logic             reg_wr_en_o;
  logic [7:0]       reg_wdata_o;
  logic             busy_o;

  modport slave (
    input  slave_address_i, addr_ready_i, start_det_i, stop_det_i,
           rx_valid_i, rx_byte_i, tx_load_i, master_nack_i, reg_rdata_i,
    output ack_valid_o, ack_o, tx_byte_o, reg_addr_o, reg_wr_en_o,
           reg_wdata_o, busy_o
  );

  modport master (
    output slave_address_i, addr_ready_i, start_det_i, stop_det_i,
           rx_valid_i, rx_byte_i, tx_load_i, master_nack_i, reg_rdata_i,
    input  ack_valid_o, ack_o, tx_byte_o, reg_addr_o, reg_wr_en_o,
           reg_wdata_o, busy_o
  );
endinterface

// File: rtl/i2c_reg_access_ctrl.sv
// I2C transaction sequencer: address match, register pointer, write strobes,
// read data fetch and ACK/NACK decisions for the PWM register file.
module i2c_reg_access_ctrl #(
  parameter int NUM_REGS = 70,
  parameter int PTR_W    = 7,
  parameter int AUTO_INC = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  i2c_reg_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    PTR     = 3'd2,
    WR_DATA = 3'd3,
    RD_DATA = 3'd4,
    IGNORE  = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic ack_vld_d, ack_d, wr_en_d, ptr_load_d, tx_take_d;
  logic addr_match, ptr_in_range;

  logic             ack_vld_p1;
  logic             ack_p1;
  logic             wr_en_p1;
  logic [7:0]       wdata_p1;
  logic [7:0]       tx_byte_p1;
  logic [PTR_W-1:0] ptr_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NUM_REGS - 1)) return '0;
    else                           return p + PTR_W'(1);
  endfunction

  assign addr_match   = bus.addr_ready_i && (bus.rx_byte_i[7:1] == bus.slave_address_i);
  assign ptr_in_range = (int'(bus.rx_byte_i) < NUM_REGS);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // START wins over everything else in the cycle; dropped events produce no side effects.
  always_comb begin
    state_d    = state_q;
    ack_vld_d  = 1'b0;
    ack_d      = 1'b0;
    wr_en_d    = 1'b0;
    ptr_load_d = 1'b0;
    tx_take_d  = 1'b0;
    if (bus.start_det_i) begin
      state_d = ADDR;
    end else if (bus.stop_det_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR: if (bus.rx_valid_i) begin
          ack_vld_d = 1'b1;
          if (addr_match) begin
            ack_d   = 1'b1;
            state_d = bus.rx_byte_i[0] ? RD_DATA : PTR;
          end else begin
            state_d = IGNORE;
          end
        end
        PTR: if (bus.rx_valid_i) begin
          ack_vld_d = 1'b1;
          if (ptr_in_range) begin
            ack_d      = 1'b1;
            ptr_load_d = 1'b1;
            state_d    = WR_DATA;
          end else begin
            state_d = IGNORE;
          end
        end
        WR_DATA: if (bus.rx_valid_i) begin
          ack_vld_d = 1'b1;
          ack_d     = 1'b1;
          wr_en_d   = 1'b1;
        end
        RD_DATA: begin
          tx_take_d = bus.tx_load_i;
          if (bus.master_nack_i) state_d = IGNORE;
        end
        IGNORE: ack_vld_d = bus.rx_valid_i;
        default: ;
      endcase
    end
  end

  // Stage p1: registered ACK, write strobe/data, read byte and pointer.
  // The pointer advances the edge after the write strobe so the strobe carries the old address.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_vld_p1 <= 1'b0;
      ack_p1     <= 1'b0;
      wr_en_p1   <= 1'b0;
      wdata_p1   <= '0;
      tx_byte_p1 <= '0;
      ptr_q      <= '0;
    end else begin
      ack_vld_p1 <= ack_vld_d;
      ack_p1     <= ack_d;
      wr_en_p1   <= wr_en_d;
      if (wr_en_d)   wdata_p1   <= bus.rx_byte_i;
      if (tx_take_d) tx_byte_p1 <= bus.reg_rdata_i;
      if (ptr_load_d)
        ptr_q <= PTR_W'(bus.rx_byte_i);
      else if ((AUTO_INC != 0) && (tx_take_d || wr_en_p1))
        ptr_q <= next_ptr(ptr_q);
    end
  end

  assign bus.ack_valid_o = ack_vld_p1;
  assign bus.ack_o       = ack_p1;
  assign bus.reg_wr_en_o = wr_en_p1;
  assign bus.reg_wdata_o = wdata_p1;
  assign bus.tx_byte_o   = tx_byte_p1;
  assign bus.reg_addr_o  = ptr_q;
  assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_reg_access_ctrl.sv
// Directed bench for i2c_reg_access_ctrl with a small register-file model.
module tb_i2c_reg_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;
  logic [7:0] mem [0:127];

  i2c_reg_access_ctrl_if #(.PTR_W(7)) ifc ();

  i2c_reg_access_ctrl #(.NUM_REGS(70), .PTR_W(7), .AUTO_INC(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  assign ifc.reg_rdata_i = mem[ifc.reg_addr_o];

  always @(posedge clk) begin
    if (ifc.reg_wr_en_o) begin
      mem[ifc.reg_addr_o] <= ifc.reg_wdata_o;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); ifc.start_det_i = 1'b1;
    @(negedge clk); ifc.start_det_i = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); ifc.stop_det_i = 1'b1;
    @(negedge clk); ifc.stop_det_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic exp_ack, input string tag);
    @(negedge clk); ifc.rx_valid_i = 1'b1; ifc.rx_byte_i = b;
    @(negedge clk); ifc.rx_valid_i = 1'b0;
    check({tag, "_vld"}, 32'(ifc.ack_valid_o), 32'd1);
    check({tag, "_ack"}, 32'(ifc.ack_o), 32'(exp_ack));
  endtask

  task automatic load_tx(input logic [7:0] exp_byte, input logic [6:0] exp_ptr, input string tag);
    @(negedge clk); ifc.tx_load_i = 1'b1;
    @(negedge clk); ifc.tx_load_i = 1'b0;
    check({tag, "_tx"}, 32'(ifc.tx_byte_o), 32'(exp_byte));
    check({tag, "_ptr"}, 32'(ifc.reg_addr_o), 32'(exp_ptr));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(ifc.busy_o), 32'd0);
    check({tag, "_ptr"}, 32'(ifc.reg_addr_o), 32'd0);
    check({tag, "_tx"}, 32'(ifc.tx_byte_o), 32'd0);
    check({tag, "_wdata"}, 32'(ifc.reg_wdata_o), 32'd0);
    check({tag, "_wr"}, 32'(ifc.reg_wr_en_o), 32'd0);
    check({tag, "_ackv"}, 32'(ifc.ack_valid_o), 32'd0);
    check({tag, "_ack"}, 32'(ifc.ack_o), 32'd0);
  endtask

  initial begin
    ifc.slave_address_i = 7'h52;
    ifc.addr_ready_i    = 1'b1;
    ifc.start_det_i     = 1'b0;
    ifc.stop_det_i      = 1'b0;
    ifc.rx_valid_i      = 1'b0;
    ifc.rx_byte_i       = 8'h00;
    ifc.tx_load_i       = 1'b0;
    ifc.master_nack_i   = 1'b0;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Plain write: pointer 6, two data bytes.
    pulse_start();
    check("t1_busy", 32'(ifc.busy_o), 32'd1);
    send(8'hA4, 1'b1, "t1_addr");
    send(8'h06, 1'b1, "t1_ptrbyte");
    check("t1_ptr6", 32'(ifc.reg_addr_o), 32'd6);
    send(8'h11, 1'b1, "t1_d0");
    check("t1_wr0", 32'(ifc.reg_wr_en_o), 32'd1);
    check("t1_wa0", 32'(ifc.reg_addr_o), 32'd6);
    check("t1_wd0", 32'(ifc.reg_wdata_o), 32'h11);
    send(8'h22, 1'b1, "t1_d1");
    check("t1_wa1", 32'(ifc.reg_addr_o), 32'd7);
    check("t1_wd1", 32'(ifc.reg_wdata_o), 32'h22);
    pulse_stop();
    check("t1_ptr8", 32'(ifc.reg_addr_o), 32'd8);
    check("t1_idle", 32'(ifc.busy_o), 32'd0);
    check("t1_nwr", 32'(wr_count), 32'd2);

    // Address mismatch: everything NACKed, no writes.
    pulse_start();
    send(8'hA6, 1'b0, "t2_addr");
    send(8'h55, 1'b0, "t2_data");
    check("t2_busy", 32'(ifc.busy_o), 32'd1);
    check("t2_nwr", 32'(wr_count), 32'd2);
    pulse_stop();
    check("t2_idle", 32'(ifc.busy_o), 32'd0);

    // Fill reg69/reg0 via a wrapping write, then read back through a repeated START.
    pulse_start();
    send(8'hA4, 1'b1, "t3_addr");
    send(8'h45, 1'b1, "t3_ptr");
    send(8'hAB, 1'b1, "t3_d69");
    check("t3_wa69", 32'(ifc.reg_addr_o), 32'd69);
    send(8'hCD, 1'b1, "t3_d0");
    check("t3_wa0", 32'(ifc.reg_addr_o), 32'd0);
    pulse_start();
    send(8'hA4, 1'b1, "t3_addr2");
    send(8'h45, 1'b1, "t3_ptr2");
    pulse_start();
    send(8'hA5, 1'b1, "t3_rdaddr");
    check("t3_rdptr", 32'(ifc.reg_addr_o), 32'd69);
    load_tx(8'hAB, 7'd0, "t3_rd0");
    load_tx(8'hCD, 7'd1, "t3_rd1");
    @(negedge clk); ifc.master_nack_i = 1'b1;
    @(negedge clk); ifc.master_nack_i = 1'b0;
    send(8'h99, 1'b0, "t3_ign");
    pulse_stop();
    check("t3_nwr", 32'(wr_count), 32'd4);

    // Out-of-range pointer.
    pulse_start();
    send(8'hA4, 1'b1, "t4_addr");
    send(8'h46, 1'b0, "t4_ptr70");
    check("t4_ptrkeep", 32'(ifc.reg_addr_o), 32'd1);
    send(8'h33, 1'b0, "t4_data");
    check("t4_nwr", 32'(wr_count), 32'd4);
    pulse_stop();

    // Address not yet latched: even a matching byte is NACKed.
    ifc.addr_ready_i = 1'b0;
    pulse_start();
    send(8'hA4, 1'b0, "t5_a4");
    send(8'hA0, 1'b0, "t5_a0");
    check("t5_busy", 32'(ifc.busy_o), 32'd1);
    pulse_stop();
    ifc.addr_ready_i = 1'b1;

    // START and rx byte together: byte dropped, still waiting for the address.
    @(negedge clk);
    ifc.start_det_i = 1'b1; ifc.rx_valid_i = 1'b1; ifc.rx_byte_i = 8'hA4;
    @(negedge clk);
    ifc.start_det_i = 1'b0; ifc.rx_valid_i = 1'b0;
    check("t6_noack", 32'(ifc.ack_valid_o), 32'd0);
    check("t6_busy", 32'(ifc.busy_o), 32'd1);
    send(8'hA4, 1'b1, "t6_addr");
    send(8'h06, 1'b1, "t6_ptr");

    // Reset right after a data byte is accepted: strobe must never reach the register file.
    @(negedge clk); ifc.rx_valid_i = 1'b1; ifc.rx_byte_i = 8'h77;
    @(negedge clk); ifc.rx_valid_i = 1'b0; rst = 1'b1;
    #1;
    check_idle_outputs("t6_rst");
    repeat (2) @(negedge clk);
    check("t6_nwr", 32'(wr_count), 32'd4);
    rst = 1'b0;

    check("mem6", 32'(mem[6]), 32'h11);
    check("mem7", 32'(mem[7]), 32'h22);
    check("mem69", 32'(mem[69]), 32'hAB);
    check("mem0", 32'(mem[0]), 32'hCD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
